// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking-bay occupancy tracker.
package parking_pkg;

  // Debounce FSM states, two-bit encoding.
  typedef enum logic [1:0] {
    VACANT    = 2'd0,
    ARRIVING  = 2'd1,
    OCCUPIED  = 2'd2,
    DEPARTING = 2'd3
  } state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int unsigned DUR_W_DEF           = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // First stage may go metastable; second stage gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/occupancy_tracker.sv
// Debounced bay-occupancy tracker with arrive/depart pulses and an
// occupancy duration counter. The duration counter is built only when
// OCCUPANCY_DURATION_EN is defined; otherwise duration is tied to 0.
module occupancy_tracker
  import parking_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned DUR_W           = DUR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             parked,
  input  logic             tick_1hz,
  output logic             occupied,
  output logic             arrive,
  output logic             depart,
  output logic [DUR_W-1:0] duration
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             psync;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             occupied_nxt, arrive_nxt, depart_nxt;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (parked),
    .q     (psync)
  );

  // State, debounce count and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= VACANT;
      cnt      <= '0;
      occupied <= 1'b0;
      arrive   <= 1'b0;
      depart   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      occupied <= occupied_nxt;
      arrive   <= arrive_nxt;
      depart   <= depart_nxt;
    end
  end

  // Next-state logic: a level change is accepted only after it stays stable
  // through the full debounce window; any reversion aborts silently.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    arrive_nxt = 1'b0;
    depart_nxt = 1'b0;
    unique case (state)
      VACANT: begin
        if (psync) begin
          state_nxt = ARRIVING;
          cnt_nxt   = '0;
        end
      end
      ARRIVING: begin
        if (!psync) begin
          state_nxt = VACANT;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt  = OCCUPIED;
          arrive_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      OCCUPIED: begin
        if (!psync) begin
          state_nxt = DEPARTING;
          cnt_nxt   = '0;
        end
      end
      DEPARTING: begin
        if (psync) begin
          state_nxt = OCCUPIED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt  = VACANT;
          depart_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = VACANT;
        cnt_nxt   = '0;
      end
    endcase
    occupied_nxt = (state_nxt == OCCUPIED) || (state_nxt == DEPARTING);
  end

`ifdef OCCUPANCY_DURATION_EN
  logic [DUR_W-1:0] dur_q;

  // Duration: zero on arrival (a tick landing in the arrive cycle is dropped),
  // count seconds while occupied, saturate, hold while vacant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dur_q <= '0;
    end else if (arrive_nxt || arrive) begin
      dur_q <= '0;
    end else if (tick_1hz && occupied && (dur_q != '1)) begin
      dur_q <= dur_q + DUR_W'(1);
    end
  end

  assign duration = dur_q;
`else
  logic unused_tick;

  assign unused_tick = tick_1hz;
  assign duration    = '0;
`endif

endmodule

// File: tb/tb_occupancy_tracker.sv
// Randomized and directed bench for occupancy_tracker (DEBOUNCE_CYCLES=4,
// DUR_W=4) against a run-length reference model.
module tb_occupancy_tracker;

  localparam int unsigned D  = 4;
  localparam int unsigned DW = 4;
  localparam int          DUR_MAX = (1 << DW) - 1;
`ifdef OCCUPANCY_DURATION_EN
  localparam bit DUR_EN = 1'b1;
`else
  localparam bit DUR_EN = 1'b0;
`endif

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          parked   = 1'b0;
  logic          tick_1hz = 1'b0;
  logic          occupied;
  logic          arrive;
  logic          depart;
  logic [DW-1:0] duration;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: sensor delay line, accepted level, length of the
  // current run of samples disagreeing with it, pulses and seconds counter.
  bit m_s1, m_s2, m_occ, m_arr, m_dep;
  int m_run, m_dur;

  occupancy_tracker #(
    .DEBOUNCE_CYCLES (D),
    .DUR_W           (DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .parked   (parked),
    .tick_1hz (tick_1hz),
    .occupied (occupied),
    .arrive   (arrive),
    .depart   (depart),
    .duration (duration)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_s1 = 0; m_s2 = 0; m_occ = 0; m_arr = 0; m_dep = 0;
    m_run = 0; m_dur = 0;
  endfunction

  // One rising edge: a new level is accepted once psync has disagreed with
  // the accepted level for D+1 consecutive samples.
  function automatic void model_clock(input bit p, input bit t);
    bit ps      = m_s2;
    bit was_occ = m_occ;
    bit was_arr = m_arr;
    m_s2  = m_s1;
    m_s1  = p;
    m_arr = 0;
    m_dep = 0;
    if (ps != m_occ) begin
      m_run++;
      if (m_run == int'(D) + 1) begin
        m_occ = ps;
        m_run = 0;
        if (ps) m_arr = 1;
        else    m_dep = 1;
      end
    end else begin
      m_run = 0;
    end
    if (!DUR_EN)                m_dur = 0;
    else if (m_arr || was_arr)  m_dur = 0;
    else if (t && was_occ)      m_dur = (m_dur < DUR_MAX) ? m_dur + 1 : DUR_MAX;
  endfunction

  task automatic check_all(input string ctx);
    check({ctx, ".occupied"}, int'(occupied), int'(m_occ));
    check({ctx, ".arrive"},   int'(arrive),   int'(m_arr));
    check({ctx, ".depart"},   int'(depart),   int'(m_dep));
    check({ctx, ".duration"}, int'(duration), m_dur);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit p, input bit t);
    parked   = p;
    tick_1hz = t;
    @(posedge clk);
    model_clock(p, t);
    #1;
    check_all("step");
    @(negedge clk);
  endtask

  // Asynchronous reset pulse between clock edges; outputs must drop at once.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst.occupied", int'(occupied), 0);
    check("rst.arrive",   int'(arrive),   0);
    check("rst.depart",   int'(depart),   0);
    check("rst.duration", int'(duration), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Hold parked for n cycles, reporting the step index of the first pulse.
  task automatic hold(input bit p, input int n, output int pulses, output int first_at);
    pulses   = 0;
    first_at = -1;
    for (int i = 1; i <= n; i++) begin
      step(p, 1'b0);
      if ((p && arrive) || (!p && depart)) begin
        pulses++;
        if (first_at < 0) first_at = i;
      end
    end
  endtask

  initial begin
    int pulses, first_at, run_left;
    bit lvl;

    model_reset();
    repeat (2) @(negedge clk);
    check_all("por");
    rst_n = 1'b1;

    // Clean arrival: pulse after edge D+3, exactly once.
    hold(1'b1, 10, pulses, first_at);
    check("arrive_latency", first_at, int'(D) + 3);
    check("arrive_count", pulses, 1);

    // Saturating duration, then clean departure with duration held.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    check("dur_saturate", int'(duration), DUR_EN ? DUR_MAX : 0);
    hold(1'b0, 12, pulses, first_at);
    check("depart_latency", first_at, int'(D) + 3);
    check("depart_count", pulses, 1);
    check("dur_hold_vacant", int'(duration), DUR_EN ? DUR_MAX : 0);

    // Short glitch: no arrival, then a full-length hold is accepted normally.
    do_reset();
    hold(1'b1, 3, pulses, first_at);
    hold(1'b0, 8, pulses, first_at);
    check("glitch_no_arrive", pulses + int'(occupied), 0);
    hold(1'b1, 10, pulses, first_at);
    check("post_glitch_latency", first_at, int'(D) + 3);

    // Tick in the arrive cycle is dropped; the next one counts.
    do_reset();
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("tick_in_arrive", int'(duration), 0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("tick_after_arrive", int'(duration), DUR_EN ? 1 : 0);

    // Tick on the edge that leaves DEPARTING still counts.
    step(1'b1, 1'b1);
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("tick_on_depart", int'(depart) * 100 + int'(duration), DUR_EN ? 103 : 100);

    // Reset mid-debounce restarts the full latency.
    do_reset();
    hold(1'b1, 4, pulses, first_at);
    do_reset();
    hold(1'b1, 10, pulses, first_at);
    check("rst_rearm_latency", first_at, int'(D) + 3);
    check("rst_rearm_count", pulses, 1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    do_reset();

    // Random bouncing sensor with random ticks and occasional resets.
    lvl = 1'b0;
    run_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        lvl      = ~lvl;
        run_left = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5))
                                               : int'($urandom_range(6, 40));
      end
      run_left--;
      if ($urandom_range(0, 999) == 0) do_reset();
      step(lvl, $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/occupancy_tracker.md
OCCUPANCY_TRACKER -- requirements
Module: occupancy_tracker

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, cycles `parked` must be stable before a state change is accepted (legal minimum 2).
REQ-002 Parameter DUR_W, default 16, width of the `duration` output.
REQ-003 Port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 Port parked, input, 1, raw bay-occupied level from the sensor stage, asynchronous to clk, may bounce.
REQ-006 Port tick_1hz, input, 1, one-clk-wide pulse once per second, synchronous to clk.
REQ-007 Port occupied, output, 1, debounced occupancy level.
REQ-008 Port arrive, output, 1, one-clk pulse on accepted vacant-to-occupied transition.
REQ-009 Port depart, output, 1, one-clk pulse on accepted occupied-to-vacant transition.
REQ-010 Port duration, output, DUR_W, whole seconds of the current or most recent occupancy.

Function
REQ-011 `parked` SHALL pass a two-flop synchronizer; only the second-stage output (psync) feeds the FSM.
REQ-012 FSM states SHALL be VACANT, ARRIVING, OCCUPIED, DEPARTING.
REQ-013 VACANT: psync=1 -> ARRIVING with debounce count cleared to 0; else stay.
REQ-014 ARRIVING: psync=0 -> VACANT, no pulse; psync=1 and count==DEBOUNCE_CYCLES-1 -> OCCUPIED with arrive=1 next cycle; else count+1.
REQ-015 OCCUPIED: psync=0 -> DEPARTING with count cleared; else stay.
REQ-016 DEPARTING: psync=1 -> OCCUPIED, no pulse; psync=0 and count==DEBOUNCE_CYCLES-1 -> VACANT with depart=1 next cycle; else count+1.
REQ-017 Latency: with `parked` held high from the first clk edge that samples it high, arrive SHALL be high exactly in the cycle after edge DEBOUNCE_CYCLES+3; depart is symmetric.
REQ-018 occupied SHALL be 1 in OCCUPIED and DEPARTING, 0 in VACANT and ARRIVING; all outputs registered.
REQ-019 The debounce counter SHALL be ceil(log2(DEBOUNCE_CYCLES)) bits wide and never wrap.
REQ-020 duration SHALL clear to 0 in the cycle arrive asserts, increment by 1 on each tick_1hz while occupied=1, saturate at all-ones, and hold its value while vacant.
REQ-021 tick_1hz coincident with the arrive cycle: the clear wins, so duration = 0.
REQ-022 tick_1hz in the cycle the FSM leaves DEPARTING: it counts, since occupied is still 1 in that cycle.
REQ-023 A glitch shorter than DEBOUNCE_CYCLES SHALL produce no pulse and no change in occupied or duration.

Reset
REQ-024 rst_n low SHALL asynchronously force: state VACANT, synchronizer flops 0, count 0, occupied 0, arrive 0, depart 0, duration 0.
REQ-025 Deassertion mid-debounce SHALL restart from VACANT; a parked bay is re-accepted after the full REQ-017 latency, with one arrive pulse.

Configuration
REQ-026 With macro OCCUPANCY_DURATION_EN defined, REQ-020 to REQ-022 apply.
REQ-027 Without OCCUPANCY_DURATION_EN, the duration counter SHALL not be built, duration SHALL be constant 0, tick_1hz SHALL be ignored, and the port list SHALL be unchanged.

Structure
REQ-028 Package parking_pkg SHALL hold the FSM state typedef (2-bit encoding) and the default DEBOUNCE_CYCLES and DUR_W constants.
REQ-029 The synchronizer SHALL be a separate sub-module, sync_2ff; all else stays in occupancy_tracker.

Verification (bench uses DEBOUNCE_CYCLES=4, DUR_W=4, macro defined)
REQ-030 parked 0->1 held -> arrive pulses once in cycle after edge 7; occupied=1 from the same cycle; duration=0.
REQ-031 parked high 3 cycles then low -> no arrive, occupied stays 0, state returns to VACANT.
REQ-032 Occupied, 20 tick_1hz pulses -> duration saturates at 15; parked low held -> depart pulses once; duration holds 15.
REQ-033 tick_1hz asserted in the arrive cycle -> duration=0; next tick -> 1.
REQ-034 rst_n pulsed low in ARRIVING with parked high -> all outputs 0 immediately; after release, arrive 7 edges later, exactly one pulse.
REQ-035 Macro undefined, occupied with 5 ticks -> duration stays 0; arrive and depart timing unchanged.
